eviction_write_buffer: RTL and testbench



---
 rtl/eviction_write_buffer_pkg.sv | 14 +
 rtl/eviction_write_buffer_if.sv | 28 ++
 rtl/evb_entry_array.sv | 79 +++++++
 rtl/eviction_write_buffer.sv | 119 +++++++++++
 tb/tb_eviction_write_buffer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eviction_write_buffer_pkg.sv
// Types and constants shared by the L2 eviction/write buffer and its entry array.
package rv32i_types;
  typedef logic [255:0] cache_line_t;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_TAG_W       = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP    = 2'd1,
    PMEM_RD = 2'd2,
    DRAIN   = 2'd3
  } evb_state_t;
endpackage

// File: rtl/eviction_write_buffer_if.sv
// L2-side request port and adaptor-side memory port of the eviction write buffer.
interface eviction_write_buffer_if #(
  parameter int LINE_W = 256
) ();
  logic [31:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/evb_entry_array.sv
// Circular FIFO of dirty lines with a parallel tag lookup; writes to a resident
// line coalesce in place, so at most one valid entry ever matches a tag.
module evb_entry_array
  import rv32i_types::*;
#(
  parameter int DEPTH       = 4,
  parameter int LINE_W      = $bits(cache_line_t),
  parameter int OFFSET_BITS = LINE_OFFSET_BITS,
  localparam int TAG_W      = 32 - OFFSET_BITS,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] hit_data_o,
  input  logic              push_i,
  input  logic              coalesce_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [TAG_W-1:0]  head_tag_o,
  output logic [LINE_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o
);
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  hit_idx;

  always_comb begin
    hit_o   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
        hit_o   = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign hit_data_o  = data_q[hit_idx];
  assign head_tag_o  = tag_q[head_q];
  assign head_data_o = data_q[head_q];
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));

  // Pointers are PTR_W bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= lookup_tag_i;
        data_q[tail_q]  <= wr_data_i;
        tail_q          <= tail_q + 1'b1;
      end
      if (coalesce_i) begin
        data_q[hit_idx] <= wr_data_i;
      end
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end
endmodule

// File: rtl/eviction_write_buffer.sv
// Victim/write buffer between the L2 memory port and the cacheline adaptor.
// state   | meaning
// IDLE    | arbitrate: read > write > drain
// RESP    | one-cycle mem_resp to the L2
// PMEM_RD | read miss forwarded to the adaptor
// DRAIN   | write the oldest buffered line to the adaptor
module eviction_write_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH       = 4,
  parameter int LINE_W      = $bits(cache_line_t),
  parameter int OFFSET_BITS = LINE_OFFSET_BITS,
  localparam int TAG_W      = 32 - OFFSET_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  eviction_write_buffer_if.slave  bus,
  output logic                    empty,
  output logic                    full
);
  evb_state_t        state_q, state_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              push, coalesce, pop;
  logic              hit;
  logic [LINE_W-1:0] hit_data;
  logic [TAG_W-1:0]  head_tag;
  logic [LINE_W-1:0] head_data;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_addr_bits;

  assign req_tag          = bus.mem_address[31:OFFSET_BITS];
  assign unused_addr_bits = ^bus.mem_address[OFFSET_BITS-1:0];

  evb_entry_array #(
    .DEPTH       (DEPTH),
    .LINE_W      (LINE_W),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_entries (
    .clk          (clk),
    .rst_n        (reset_n),
    .lookup_tag_i (req_tag),
    .hit_o        (hit),
    .hit_data_o   (hit_data),
    .push_i       (push),
    .coalesce_i   (coalesce),
    .wr_data_i    (bus.mem_wdata),
    .pop_i        (pop),
    .head_tag_o   (head_tag),
    .head_data_o  (head_data),
    .empty_o      (empty),
    .full_o       (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    push     = 1'b0;
    coalesce = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read) begin
          if (hit) begin
            rdata_d = hit_data;
            state_d = RESP;
          end else begin
            state_d = PMEM_RD;
          end
        end else if (bus.mem_write) begin
          if (hit) begin
            coalesce = 1'b1;
            state_d  = RESP;
          end else if (!full) begin
            push    = 1'b1;
            state_d = RESP;
          end else begin
            // Make room; the write stays pending and is re-arbitrated in IDLE.
            state_d = DRAIN;
          end
        end else if (!empty) begin
          state_d = DRAIN;
        end
      end
      RESP: state_d = IDLE;
      PMEM_RD: begin
        if (bus.pmem_resp) begin
          rdata_d = bus.pmem_rdata;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (bus.pmem_resp) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Adaptor strobes are decoded straight from the state register so reset drops them at once.
  assign bus.mem_resp     = (state_q == RESP);
  assign bus.mem_rdata    = rdata_q;
  assign bus.pmem_read    = (state_q == PMEM_RD);
  assign bus.pmem_write   = (state_q == DRAIN);
  assign bus.pmem_address = (state_q == DRAIN)   ? {head_tag, {OFFSET_BITS{1'b0}}} :
                            (state_q == PMEM_RD) ? {req_tag, {OFFSET_BITS{1'b0}}}  : 32'd0;
  assign bus.pmem_wdata   = (state_q == DRAIN) ? head_data : '0;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed and randomized checks of eviction_write_buffer against a line-level queue model.
module tb_eviction_write_buffer;
  localparam int DEPTH = 4;

  typedef logic [26:0]  tag_t;
  typedef logic [255:0] line_t;
  typedef struct {
    tag_t  tag;
    line_t data;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic empty, full;

  eviction_write_buffer_if #(.LINE_W(256)) bus ();

  eviction_write_buffer #(
    .DEPTH       (DEPTH),
    .LINE_W      (256),
    .OFFSET_BITS (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  ent_t  mq[$];
  line_t mem_model[tag_t];
  logic [31:0] drain_addr_log[$];
  line_t       drain_data_log[$];
  int pmem_rd_cycles = 0;
  int excl_viol = 0;
  bit adp_stall = 1'b1;
  int adp_lat = 2;
  int busy = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int find_tag(input tag_t t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  always @(negedge clk) begin
    if (bus.pmem_read) pmem_rd_cycles++;
    if (bus.pmem_read && bus.pmem_write) excl_viol++;
    assert (!(bus.mem_read && bus.mem_write)) else $error("illegal mem_read with mem_write");
  end

  // Adaptor model: the expected drain order is the model queue, memory is mem_model.
  task automatic adp_drain();
    ent_t e;
    drain_addr_log.push_back(bus.pmem_address);
    drain_data_log.push_back(bus.pmem_wdata);
    chk("drain_model_has_line", mq.size() != 0, 1'b1);
    if (mq.size() != 0) begin
      e = mq.pop_front();
      chk("drain_addr", bus.pmem_address, {e.tag, 5'b0});
      chk("drain_data", bus.pmem_wdata, e.data);
      mem_model[e.tag] = e.data;
    end
  endtask

  task automatic adp_read();
    tag_t t = bus.pmem_address[31:5];
    chk("pmem_rd_addr", bus.pmem_address, {bus.mem_address[31:5], 5'b0});
    if (!mem_model.exists(t)) mem_model[t] = rand_line();
    bus.pmem_rdata = mem_model[t];
  endtask

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (!reset_n || adp_stall || !(bus.pmem_read || bus.pmem_write)) begin
        busy = 0;
      end else begin
        busy++;
        if (busy >= adp_lat) begin
          busy = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) adp_drain();
          else adp_read();
        end
      end
    end
  end

  // lat counts the request cycle as 1; an immediately serviced request gives 2.
  task automatic l2_req(input bit wr, input logic [31:0] a, input line_t wd,
                        output int lat, output int rd_cyc, output line_t rd);
    int start_rd = pmem_rd_cycles;
    bit got = 1'b0;
    bus.mem_address = a;
    bus.mem_wdata   = wd;
    bus.mem_write   = wr;
    bus.mem_read    = !wr;
    lat = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp) begin
        got = 1'b1;
        break;
      end
    end
    rd     = bus.mem_rdata;
    rd_cyc = pmem_rd_cycles - start_rd;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    chk("req_completed", got, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input line_t d, output int lat);
    int rc, idx;
    line_t rd;
    tag_t t = a[31:5];
    l2_req(1'b1, a, d, lat, rc, rd);
    idx = find_tag(t);
    if (idx >= 0) mq[idx].data = d;
    else begin
      chk("wr_room", mq.size() < DEPTH, 1'b1);
      mq.push_back('{t, d});
    end
    chk("wr_no_pmem_read", rc, 0);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output int rc, output line_t rd);
    int idx;
    line_t exp;
    tag_t t = a[31:5];
    l2_req(1'b0, a, '0, lat, rc, rd);
    idx = find_tag(t);
    if (idx >= 0) begin
      chk("rd_hit_data", rd, mq[idx].data);
      chk("rd_hit_no_pmem", rc, 0);
    end else begin
      exp = 'x;
      if (mem_model.exists(t)) exp = mem_model[t];
      chk("rd_miss_data", rd, exp);
      chk("rd_miss_pmem", rc != 0, 1'b1);
    end
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
  endtask

  task automatic wait_drained();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (empty && !bus.pmem_write) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", ok, 1'b1);
    chk("model_drained", mq.size(), 0);
  endtask

  initial begin
    int lat, rc;
    line_t rd, d1, d2;
    logic [31:0] a;

    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_resp", bus.mem_resp, 1'b0);
    chk("rst_mem_rdata", bus.mem_rdata, '0);
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_pmem_address", bus.pmem_address, '0);
    chk("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: buffered write then same-line read served from the buffer, adaptor stalled
    adp_stall = 1'b1;
    d1 = rand_line();
    do_write(32'h0000_1040, d1, lat);
    chk("t1_wr_lat", lat, 2);
    do_read(32'h0000_1058, lat, rc, rd);
    chk("t1_rd_lat", lat, 2);
    chk("t1_rd_data", rd, d1);
    chk("t1_rd_no_pmem", rc, 0);
    drain_addr_log.delete();
    adp_lat = 2;
    adp_stall = 1'b0;
    wait_drained();
    chk("t1_drains", drain_addr_log.size(), 1);

    // 2: full buffer, a fifth write forces one drain of the oldest line
    adp_stall = 1'b1;
    drain_addr_log.delete();
    for (int i = 1; i <= 4; i++) begin
      do_write(32'h100 * i, rand_line(), lat);
      chk("t2_fill_lat", lat, 2);
    end
    chk("t2_full", full, 1'b1);
    adp_lat = 3;
    adp_stall = 1'b0;
    do_write(32'h500, rand_line(), lat);
    chk("t2_fifth_lat", lat, 6);
    chk("t2_one_drain", drain_addr_log.size(), 1);
    chk("t2_drain_addr", drain_addr_log[0], 32'h100);
    wait_drained();
    for (int i = 0; i < 5; i++) chk("t2_order", drain_addr_log[i], 32'h100 * (i + 1));

    // 3: coalescing two writes to one line gives a single drain of the newest data
    adp_stall = 1'b1;
    drain_addr_log.delete();
    drain_data_log.delete();
    d1 = rand_line();
    d2 = rand_line();
    do_write(32'h100, d1, lat);
    do_write(32'h100, d2, lat);
    chk("t3_coalesce_lat", lat, 2);
    adp_stall = 1'b0;
    wait_drained();
    chk("t3_one_drain", drain_data_log.size(), 1);
    chk("t3_drain_data", drain_data_log[0], d2);

    // 4: read miss with a 10-cycle adaptor
    adp_lat = 10;
    do_read(32'h800, lat, rc, rd);
    chk("t4_pmem_rd_cycles", rc, 10);
    chk("t4_lat", lat, 12);
    chk("t4_empty", empty, 1'b1);

    // 5: FIFO order for three lines, then six lines around the wrap
    adp_stall = 1'b1;
    drain_addr_log.delete();
    for (int i = 0; i < 3; i++) do_write(32'h4000 + 32'h20 * i, rand_line(), lat);
    adp_lat = 2;
    adp_stall = 1'b0;
    wait_drained();
    for (int i = 0; i < 3; i++) chk("t5_order", drain_addr_log[i], 32'h4000 + 32'h20 * i);
    adp_stall = 1'b1;
    drain_addr_log.delete();
    for (int i = 0; i < 4; i++) do_write(32'h5000 + 32'h20 * i, rand_line(), lat);
    adp_stall = 1'b0;
    for (int i = 4; i < 6; i++) do_write(32'h5000 + 32'h20 * i, rand_line(), lat);
    wait_drained();
    chk("t5_wrap_count", drain_addr_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("t5_wrap_order", drain_addr_log[i], 32'h5000 + 32'h20 * i);

    // 6: reset in the middle of a drain discards the buffered lines
    adp_stall = 1'b1;
    d1 = rand_line();
    do_write(32'h2000, d1, lat);
    do_write(32'h3000, rand_line(), lat);
    repeat (3) @(negedge clk);
    chk("t6_in_drain", bus.pmem_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_pmem_write", bus.pmem_write, 1'b0);
    chk("t6_pmem_read", bus.pmem_read, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_mem_resp", bus.mem_resp, 1'b0);
    mq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    adp_lat = 4;
    adp_stall = 1'b0;
    do_read(32'h2000, lat, rc, rd);
    chk("t6_rd_from_pmem", rc, 4);

    // randomized traffic over a small line pool so hits, coalesces and full stalls occur
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      adp_lat = $urandom_range(1, 6);
      a = 32'h0001_0000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) do_write(a, rand_line(), lat);
      else do_read(a, lat, rc, rd);
    end
    wait_drained();
    chk("pmem_exclusive", excl_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end
endmodule
